vga_multi_circle_gen: RTL and testbench

- Parametrised successor of the 1080p single-circle sync/render block.
- Generates VGA timing from parameters, with programmable sync polarity, and renders N_OBJ filled circles over a background colour.
- Each circle has its own centre, radius, colour and enable.
- Object attributes are shadow-latched once per frame (tear-free).
- Colour, sync and coordinate outputs are pipeline-aligned.
- Sits between the pixel-clock MMCM and the Basys-3 VGA pins.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/circle_hit.sv | 72 +++++++
 rtl/vga_multi_circle_gen.sv | 162 ++++++++++++++++
 tb/tb_vga_multi_circle_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pipeline constants and the per-pixel timing payload.
//   No ports; imported by circle_hit and vga_multi_circle_gen.
package vga_pkg;

    // 1080p60 defaults
    localparam int unsigned H_VISIBLE_DEF = 1920;
    localparam int unsigned H_FP_DEF      = 88;
    localparam int unsigned H_SYNC_DEF    = 44;
    localparam int unsigned H_BP_DEF      = 148;
    localparam int unsigned V_VISIBLE_DEF = 1080;
    localparam int unsigned V_FP_DEF      = 4;
    localparam int unsigned V_SYNC_DEF    = 5;
    localparam int unsigned V_BP_DEF      = 36;

    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned COORD_W  = 12;
    localparam int unsigned RGB_W    = 12;

    // Timing attributes that travel alongside the colour pipeline
    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               vis;
        logic               fs;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } timing_t;

    // Total line/frame length from visible area and porches
    function automatic int unsigned calc_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/circle_hit.sv
// Per-object hit test: S1 distance, S2 squares, S3 compare (combinational, registered by the top).
//   clk_148Mhz/reset : pixel clock, async active-high reset
//   i_h_cnt/i_v_cnt  : current raster counters
//   i_x/i_y          : signed centre, i_r: radius, i_en: object enable
//   o_hit_c          : pixel lies inside the circle (valid two clocks after the counters)
module circle_hit
    import vga_pkg::*;
#(
    parameter int unsigned R_W = 10
) (
    input  logic                      clk_148Mhz,
    input  logic                      reset,
    input  logic        [COORD_W-1:0] i_h_cnt,
    input  logic        [COORD_W-1:0] i_v_cnt,
    input  logic signed [COORD_W-1:0] i_x,
    input  logic signed [COORD_W-1:0] i_y,
    input  logic        [R_W-1:0]     i_r,
    input  logic                      i_en,
    output logic                      o_hit_c
);

    localparam int unsigned D_W  = COORD_W + 1;
    localparam int unsigned SQ_W = 2 * D_W;
    localparam int unsigned R2_W = 2 * R_W;

    logic signed [D_W-1:0]  r_dx, r_dy;
    logic        [R_W-1:0]  r_r1;
    logic                   r_en1;
    logic        [SQ_W-1:0] r_d2;
    logic        [R2_W-1:0] r_r2;
    logic                   r_en2;

    // Squares evaluated at full product width so negative offsets never truncate
    logic signed [SQ_W-1:0] w_dx2, w_dy2;
    logic        [R2_W-1:0] w_r2;

    assign w_dx2 = r_dx * r_dx;
    assign w_dy2 = r_dy * r_dy;
    assign w_r2  = r_r1 * r_r1;

    // S1: offsets from the centre; radius and enable follow along
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            r_dx  <= '0;
            r_dy  <= '0;
            r_r1  <= '0;
            r_en1 <= 1'b0;
        end else begin
            r_dx  <= $signed({1'b0, i_h_cnt}) - $signed({i_x[COORD_W-1], i_x});
            r_dy  <= $signed({1'b0, i_v_cnt}) - $signed({i_y[COORD_W-1], i_y});
            r_r1  <= i_r;
            r_en1 <= i_en;
        end
    end

    // S2: squared distance and squared radius
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            r_d2  <= '0;
            r_r2  <= '0;
            r_en2 <= 1'b0;
        end else begin
            r_d2  <= $unsigned(w_dx2) + $unsigned(w_dy2);
            r_r2  <= w_r2;
            r_en2 <= r_en1;
        end
    end

    // S3: inclusive compare, so radius 0 still lights the centre pixel
    assign o_hit_c = r_en2 && (r_d2 <= SQ_W'(r_r2));

endmodule

// File: rtl/vga_multi_circle_gen.sv
// VGA timing generator rendering N_OBJ filled circles over a background colour.
//   clk_148Mhz/reset         : pixel clock, async active-high reset
//   obj_x/obj_y/obj_r        : per-object signed centre and radius (object i in slice i)
//   obj_rgb/obj_en/bg_rgb    : per-object colour and enable, background colour
//   h_sync/v_sync            : syncs with programmable polarity
//   red/green/blue           : pixel colour, black outside the visible area
//   video_on/pixel_x/pixel_y : visible flag and coordinates of the coloured pixel
//   frame_start              : one-cycle pulse at pixel (0,0)
module vga_multi_circle_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned N_OBJ     = 2,
    parameter int unsigned R_W       = 10
) (
    input  logic                       clk_148Mhz,
    input  logic                       reset,
    input  logic [N_OBJ*COORD_W-1:0]   obj_x,
    input  logic [N_OBJ*COORD_W-1:0]   obj_y,
    input  logic [N_OBJ*R_W-1:0]       obj_r,
    input  logic [N_OBJ*RGB_W-1:0]     obj_rgb,
    input  logic [N_OBJ-1:0]           obj_en,
    input  logic [RGB_W-1:0]           bg_rgb,
    output logic                       h_sync,
    output logic                       v_sync,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue,
    output logic                       video_on,
    output logic [COORD_W-1:0]         pixel_x,
    output logic [COORD_W-1:0]         pixel_y,
    output logic                       frame_start
);

    localparam int unsigned H_TOT = calc_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOT = calc_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

    localparam timing_t RST_T = '{hs: !HS_POL, vs: !VS_POL, vis: 1'b0, fs: 1'b0, x: '0, y: '0};

    logic [COORD_W-1:0]       r_h_cnt, r_v_cnt;
    timing_t                  w_raw;
    timing_t                  r_dly [PIPE_LAT];
    logic [N_OBJ*COORD_W-1:0] r_sh_x, r_sh_y;
    logic [N_OBJ*R_W-1:0]     r_sh_r;
    logic [N_OBJ*RGB_W-1:0]   r_sh_rgb;
    logic [N_OBJ-1:0]         r_sh_en;
    logic [RGB_W-1:0]         r_sh_bg;
    logic [N_OBJ-1:0]         w_hit;
    logic [RGB_W-1:0]         w_sel;
    logic [RGB_W-1:0]         r_rgb;

    // Raster counters
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + COORD_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + COORD_W'(1);
        end
    end

    // Undelayed timing attributes of the current counter position
    always_comb begin
        w_raw     = RST_T;
        w_raw.hs  = (r_h_cnt >= HS_START && r_h_cnt < HS_END) ? HS_POL : !HS_POL;
        w_raw.vs  = (r_v_cnt >= VS_START && r_v_cnt < VS_END) ? VS_POL : !VS_POL;
        w_raw.vis = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        w_raw.fs  = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_raw.x   = r_h_cnt;
        w_raw.y   = r_v_cnt;
    end

    // Timing delay line matching the circle pipeline depth
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) r_dly[i] <= RST_T;
        end else begin
            r_dly[0] <= w_raw;
            for (int i = 1; i < int'(PIPE_LAT); i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Attributes are captured at the start of the first blanking line so a frame never tears
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) begin
            r_sh_x   <= '0;
            r_sh_y   <= '0;
            r_sh_r   <= '0;
            r_sh_rgb <= '0;
            r_sh_en  <= '0;
            r_sh_bg  <= '0;
        end else if (r_h_cnt == '0 && r_v_cnt == V_VIS) begin
            r_sh_x   <= obj_x;
            r_sh_y   <= obj_y;
            r_sh_r   <= obj_r;
            r_sh_rgb <= obj_rgb;
            r_sh_en  <= obj_en;
            r_sh_bg  <= bg_rgb;
        end
    end

    // One hit tester per object
    for (genvar g = 0; g < int'(N_OBJ); g++) begin : g_obj
        circle_hit #(.R_W(R_W)) u_hit (
            .clk_148Mhz (clk_148Mhz),
            .reset      (reset),
            .i_h_cnt    (r_h_cnt),
            .i_v_cnt    (r_v_cnt),
            .i_x        (r_sh_x[g*COORD_W +: COORD_W]),
            .i_y        (r_sh_y[g*COORD_W +: COORD_W]),
            .i_r        (r_sh_r[g*R_W +: R_W]),
            .i_en       (r_sh_en[g]),
            .o_hit_c    (w_hit[g])
        );
    end

    // Priority select: scanning from the top leaves the lowest-index hit in w_sel
    always_comb begin
        w_sel = r_sh_bg;
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (w_hit[i]) w_sel = r_sh_rgb[i*RGB_W +: RGB_W];
        end
    end

    // Colour register forms the last pipeline stage
    always_ff @(posedge clk_148Mhz or posedge reset) begin
        if (reset) r_rgb <= '0;
        else       r_rgb <= r_dly[PIPE_LAT-2].vis ? w_sel : '0;
    end

    assign h_sync      = r_dly[PIPE_LAT-1].hs;
    assign v_sync      = r_dly[PIPE_LAT-1].vs;
    assign video_on    = r_dly[PIPE_LAT-1].vis;
    assign frame_start = r_dly[PIPE_LAT-1].fs;
    assign pixel_x     = r_dly[PIPE_LAT-1].x;
    assign pixel_y     = r_dly[PIPE_LAT-1].y;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];

endmodule

// File: tb/tb_vga_multi_circle_gen.sv
// Bench: two DUT instances (medium 2-object POL=1, small 1-object POL=0) checked every cycle
// against a frame-level behavioural model, plus directed pixel and timing expectations.
module tb_vga_multi_circle_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
        logic [11:0] rgb;
        logic [11:0] px;
        logic [11:0] py;
    } exp_t;

    // Medium config A
    localparam int A_HV = 112, A_HFP = 2, A_HS = 3, A_HBP = 3;
    localparam int A_VV = 112, A_VFP = 1, A_VS = 2, A_VBP = 1;
    localparam int A_HT = A_HV + A_HFP + A_HS + A_HBP;
    localparam int A_FT = A_HT * (A_VV + A_VFP + A_VS + A_VBP);
    localparam int A_L  = A_VV * A_HT;
    // Small config B
    localparam int B_HV = 16, B_HFP = 2, B_HS = 3, B_HBP = 3;
    localparam int B_VV = 8,  B_VFP = 1, B_VS = 2, B_VBP = 1;
    localparam int B_HT = B_HV + B_HFP + B_HS + B_HBP;
    localparam int B_FT = B_HT * (B_VV + B_VFP + B_VS + B_VBP);
    localparam int B_L  = B_VV * B_HT;

    // Frame-1 attribute set for A: obj0 (100,100) r10 red, obj1 (-5,-5) r10 green, bg blue
    localparam logic [23:0] A1_X = {12'hFFB, 12'd100};
    localparam logic [23:0] A1_Y = {12'hFFB, 12'd100};
    localparam logic [19:0] A1_R = {10'd10, 10'd10};
    localparam logic [23:0] A1_C = {12'h0F0, 12'hF00};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] a_x, a_y, a_c;
    logic [19:0] a_r;
    logic [1:0]  a_en;
    logic [11:0] a_bg;
    logic a_hs, a_vs, a_von, a_fs;
    logic [3:0] a_red, a_grn, a_blu;
    logic [11:0] a_px, a_py;

    logic [11:0] b_x, b_y, b_c, b_bg;
    logic [3:0]  b_r;
    logic        b_en;
    logic b_hs, b_vs, b_von, b_fs;
    logic [3:0] b_red, b_grn, b_blu;
    logic [11:0] b_px, b_py;

    vga_multi_circle_gen #(
        .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .N_OBJ(2), .R_W(10)
    ) u_dut_a (
        .clk_148Mhz(clk), .reset(reset),
        .obj_x(a_x), .obj_y(a_y), .obj_r(a_r), .obj_rgb(a_c), .obj_en(a_en), .bg_rgb(a_bg),
        .h_sync(a_hs), .v_sync(a_vs), .red(a_red), .green(a_grn), .blue(a_blu),
        .video_on(a_von), .pixel_x(a_px), .pixel_y(a_py), .frame_start(a_fs)
    );

    vga_multi_circle_gen #(
        .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .N_OBJ(1), .R_W(4)
    ) u_dut_b (
        .clk_148Mhz(clk), .reset(reset),
        .obj_x(b_x), .obj_y(b_y), .obj_r(b_r), .obj_rgb(b_c), .obj_en(b_en), .bg_rgb(b_bg),
        .h_sync(b_hs), .v_sync(b_vs), .red(b_red), .green(b_grn), .blue(b_blu),
        .video_on(b_von), .pixel_x(b_px), .pixel_y(b_py), .frame_start(b_fs)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_vec(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for flat pixel index p of a frame, from the timing and geometry rules
    function automatic exp_t model(input int p, input int hv, input int hfp, input int hsw,
                                   input int hbp, input int vv, input int vfp, input int vsw,
                                   input int vbp, input bit hpol, input bit vpol,
                                   input int nobj, input int rw,
                                   input logic [23:0] xs, input logic [23:0] ys,
                                   input logic [19:0] rs, input logic [23:0] cs,
                                   input logic [1:0] ens, input logic [11:0] bg);
        exp_t e;
        int htot, vtot, h, v, dx, dy, ri;
        logic [19:0] mask;
        htot = hv + hfp + hsw + hbp;
        vtot = vv + vfp + vsw + vbp;
        h = p % htot;
        v = (p / htot) % vtot;
        e.hs  = (h >= hv + hfp && h < hv + hfp + hsw) ? hpol : !hpol;
        e.vs  = (v >= vv + vfp && v < vv + vfp + vsw) ? vpol : !vpol;
        e.von = (h < hv) && (v < vv);
        e.fs  = (h == 0) && (v == 0);
        e.px  = 12'(h);
        e.py  = 12'(v);
        e.rgb = 12'h000;
        mask  = (20'd1 << rw) - 20'd1;
        if (e.von) begin
            e.rgb = bg;
            for (int i = nobj - 1; i >= 0; i--) begin
                dx = h - int'($signed(xs[i*12 +: 12]));
                dy = v - int'($signed(ys[i*12 +: 12]));
                ri = int'((rs >> (i * rw)) & mask);
                if (ens[i] && (dx * dx + dy * dy <= ri * ri)) e.rgb = cs[i*12 +: 12];
            end
        end
        return e;
    endfunction

    function automatic exp_t rst_exp(input bit hpol, input bit vpol);
        exp_t e;
        e = '0;
        e.hs = !hpol;
        e.vs = !vpol;
        return e;
    endfunction

    // Model state: edges since release and the attribute set each DUT is currently drawing
    int n = 0;
    logic [23:0] ma_x, ma_y, ma_c;
    logic [19:0] ma_r;
    logic [1:0]  ma_en;
    logic [11:0] ma_bg;
    logic [11:0] mb_x, mb_y, mb_c, mb_bg;
    logic [3:0]  mb_r;
    logic        mb_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0;
            ma_x <= '0; ma_y <= '0; ma_c <= '0; ma_r <= '0; ma_en <= '0; ma_bg <= '0;
            mb_x <= '0; mb_y <= '0; mb_c <= '0; mb_r <= '0; mb_en <= '0; mb_bg <= '0;
        end else begin
            if (n % A_FT == A_L) begin
                ma_x <= a_x; ma_y <= a_y; ma_c <= a_c; ma_r <= a_r; ma_en <= a_en; ma_bg <= a_bg;
            end
            if (n % B_FT == B_L) begin
                mb_x <= b_x; mb_y <= b_y; mb_c <= b_c; mb_r <= b_r; mb_en <= b_en; mb_bg <= b_bg;
            end
            n <= n + 1;
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        exp_t ea, eb, aa, ab;
        aa = '{hs: a_hs, vs: a_vs, von: a_von, fs: a_fs, rgb: {a_red, a_grn, a_blu}, px: a_px, py: a_py};
        ab = '{hs: b_hs, vs: b_vs, von: b_von, fs: b_fs, rgb: {b_red, b_grn, b_blu}, px: b_px, py: b_py};
        if (reset || n < 3) begin
            ea = rst_exp(1'b1, 1'b1);
            eb = rst_exp(1'b0, 1'b0);
        end else begin
            ea = model(n - 3, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP, 1'b1, 1'b1,
                       2, 10, ma_x, ma_y, ma_r, ma_c, ma_en, ma_bg);
            eb = model(n - 3, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP, 1'b0, 1'b0,
                       1, 4, {12'd0, mb_x}, {12'd0, mb_y}, {16'd0, mb_r}, {12'd0, mb_c},
                       {1'b0, mb_en}, mb_bg);
        end
        chk_vec("A_pixel", aa, ea);
        chk_vec("B_pixel", ab, eb);
    end

    // Small-timing frame metrics of B: period and sync-active cycles per frame
    int b_cyc = 0, b_last = -1, b_hs_n = 0, b_vs_n = 0;
    always @(negedge clk) begin
        if (reset) begin
            b_cyc = 0; b_last = -1; b_hs_n = 0; b_vs_n = 0;
        end else begin
            if (b_fs) begin
                if (b_last >= 0) begin
                    chk_int("B_fs_period", b_cyc - b_last, 288);
                    chk_int("B_hs_active_per_frame", b_hs_n, 36);
                    chk_int("B_vs_active_per_frame", b_vs_n, 48);
                end
                b_last = b_cyc; b_hs_n = 0; b_vs_n = 0;
            end
            if (b_hs == 1'b0) b_hs_n++;
            if (b_vs == 1'b0) b_vs_n++;
            b_cyc++;
        end
    end

    // Random attribute churn on B, at arbitrary points in the frame
    initial begin
        b_x = 12'd4; b_y = 12'd4; b_r = 4'd2; b_c = 12'hABC; b_en = 1'b1; b_bg = 12'h123;
        forever begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                b_x  = 12'($urandom_range(0, 31)) - 12'd8;
                b_y  = 12'($urandom_range(0, 23)) - 12'd8;
                b_r  = 4'($urandom_range(0, 15));
                b_c  = 12'($urandom);
                b_en = 1'($urandom);
                b_bg = 12'($urandom);
            end
        end
    end

    // Wait for the next visible A pixel (x,y) and check its colour
    task automatic wait_px(input int x, input int y, input logic [11:0] exp, input string nm);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * A_FT + 64 && !found; k++) begin
            @(negedge clk);
            if (a_von && a_px == 12'(x) && a_py == 12'(y)) begin
                found = 1'b1;
                chk_int(nm, int'({a_red, a_grn, a_blu}), int'(exp));
            end
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout waiting for pixel (%0d,%0d)", nm, x, y);
        end
    endtask

    initial begin
        exp_t e;
        // Hand-computed pins on the model itself
        e = model(100 * A_HT + 110, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP,
                  1'b1, 1'b1, 2, 10, A1_X, A1_Y, A1_R, A1_C, 2'b11, 12'h00F);
        chk_int("model_110_100", int'(e.rgb), 'hF00);
        e = model(107 * A_HT + 107, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP,
                  1'b1, 1'b1, 2, 10, A1_X, A1_Y, A1_R, A1_C, 2'b11, 12'h00F);
        chk_int("model_107_107", int'(e.rgb), 'hF00);
        e = model(0, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP,
                  1'b1, 1'b1, 2, 10, A1_X, A1_Y, A1_R, A1_C, 2'b11, 12'h00F);
        chk_int("model_0_0", int'(e.rgb), 'h0F0);
        e = model(18, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP,
                  1'b0, 1'b0, 1, 4, '0, '0, '0, '0, '0, '0);
        chk_int("model_b_hs_18", int'(e.hs), 0);
        e = model(21, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP,
                  1'b0, 1'b0, 1, 4, '0, '0, '0, '0, '0, '0);
        chk_int("model_b_hs_21", int'(e.hs), 1);

        a_x = A1_X; a_y = A1_Y; a_r = A1_R; a_c = A1_C; a_en = 2'b11; a_bg = 12'h00F;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Frame 0: shadows still hold reset values
        wait_px(110, 100, 12'h000, "A_f0_black");
        // Frame 1
        wait_px(0, 0, 12'h0F0, "A_f1_neg_centre_0_0");
        wait_px(9, 0, 12'h00F, "A_f1_neg_centre_9_0");
        wait_px(0, 50, 12'h00F, "A_f1_bg_0_50");
        a_x = {12'd50, 12'd50}; a_y = {12'd50, 12'd50}; a_r = {10'd5, 10'd5};
        a_c = {12'hF00, 12'h0F0};
        wait_px(110, 100, 12'hF00, "A_f1_edge_110_100");
        wait_px(111, 100, 12'h00F, "A_f1_out_111_100");
        wait_px(107, 107, 12'hF00, "A_f1_diag_107_107");
        wait_px(108, 108, 12'h00F, "A_f1_diag_108_108");
        // Frame 2: new attributes, obj0 wins the overlap
        wait_px(50, 50, 12'h0F0, "A_f2_overlap_obj0");
        wait_px(0, 60, 12'h00F, "A_f2_bg_0_60");
        a_en = 2'b10;
        // Frame 3: obj0 disabled
        wait_px(50, 50, 12'hF00, "A_f3_overlap_obj1");
        a_x = {12'($urandom_range(0, 180)), 12'($urandom_range(0, 180))};
        a_y = {12'($urandom_range(0, 180)), 12'($urandom_range(0, 180))};
        a_r = 20'($urandom); a_c = 24'($urandom); a_en = 2'($urandom); a_bg = 12'($urandom);

        // Mid-frame reset, asserted away from any clock edge
        repeat ($urandom_range(100, 500)) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (700) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
